// File: rtl/adder_tree_accum.sv
// adder_tree_accum: per-beat pairwise adder tree feeding a frame accumulator.
// Each accepted beat of NUM_INPUTS operands is summed by a ceil(log2) tree whose
// boundaries are optionally registered from the input side. The tree result is
// added into a frame accumulator, and the frame total is presented on the last beat.
// Optional feature macro: ADDER_TREE_ACCUM_SAT_EN enables a saturating accumulator
// and a sticky per-frame o_ovf flag. Without it, the accumulator wraps and o_ovf is 0.
module adder_tree_accum #(
  parameter int DATAWIDTH           = 4,
  parameter int NUM_INPUTS          = 16,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter int SIGNED              = 0,
  parameter int ACC_WIDTH           = 16,
  parameter int CNT_W               = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_last,
  input  logic [DATAWIDTH-1:0] in_data [NUM_INPUTS],
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_ovf
);
  localparam int NUM_STAGES = $clog2(NUM_INPUTS);
  localparam int SUM_W      = DATAWIDTH + NUM_STAGES;

  // Number of live nodes at tree level s (odd counts round up: last node passes through).
  function automatic int lvl_cnt(input int s);
    return (NUM_INPUTS + (1 << s) - 1) >> s;
  endfunction

  // Operand extension to the full tree width. Every level lives in SUM_W bits;
  // the final level needs exactly SUM_W, so no level ever truncates.
  function automatic logic [SUM_W-1:0] ext_op(input logic [DATAWIDTH-1:0] v);
    if (SIGNED != 0) return SUM_W'($signed(v));
    else             return SUM_W'(v);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext_acc(input logic [SUM_W-1:0] v);
    if (SIGNED != 0) return ACC_WIDTH'($signed(v));
    else             return ACC_WIDTH'(v);
  endfunction

`ifdef ADDER_TREE_ACCUM_SAT_EN
  // Saturating add; MSB of the result flags that clamping happened.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    if (SIGNED != 0) begin
      s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
        return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
      else
        return {1'b0, s[ACC_WIDTH-1:0]};
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s[ACC_WIDTH])
        return {1'b1, {ACC_WIDTH{1'b1}}};
      else
        return {1'b0, s[ACC_WIDTH-1:0]};
    end
  endfunction
`endif

  // Global advance: everything moves unless a finished result is waiting on the sink.
  logic w_en;
  logic r_o_valid;
  assign w_en    = !(r_o_valid && !o_ready);
  assign i_ready = w_en;

  // Tree node values entering (w_lvl_in) and leaving (w_lvl_out) each boundary k.
  logic [SUM_W-1:0] w_lvl_in  [NUM_STAGES+1][NUM_INPUTS];
  logic [SUM_W-1:0] w_lvl_out [NUM_STAGES+1][NUM_INPUTS];
  logic [NUM_STAGES:0] w_vld_in, w_vld_out, w_lst_in, w_lst_out;

  for (genvar k = 0; k <= NUM_STAGES; k++) begin : g_bnd
    localparam int N = lvl_cnt(k);

    if (k == 0) begin : g_src
      for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_op
        assign w_lvl_in[0][j] = ext_op(in_data[j]);
      end
      assign w_vld_in[0] = i_valid;
      assign w_lst_in[0] = i_last;
    end else begin : g_add
      localparam int NP = lvl_cnt(k - 1);
      for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_pair
          assign w_lvl_in[k][j] = w_lvl_out[k-1][2*j] + w_lvl_out[k-1][2*j+1];
        end else if (2 * j < NP) begin : g_pass
          assign w_lvl_in[k][j] = w_lvl_out[k-1][2*j];
        end else begin : g_zero
          assign w_lvl_in[k][j] = '0;
        end
      end
      assign w_vld_in[k] = w_vld_out[k-1];
      assign w_lst_in[k] = w_lst_out[k-1];
    end

    if (k < NUM_PIPELINE_STAGES) begin : g_reg
      // ---- registered boundary k ----
      logic [SUM_W-1:0] r_node [N];
      logic             r_vld;
      logic             r_lst;

      // Valid tag is control state and is cleared by reset, dropping in-flight beats.
      always_ff @(posedge clk) begin
        if (!rst)      r_vld <= 1'b0;
        else if (w_en) r_vld <= w_vld_in[k];
      end

      // Node data and last tag ride along with the valid tag; no reset needed.
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_lst <= w_lst_in[k];
          for (int n = 0; n < N; n++) r_node[n] <= w_lvl_in[k][n];
        end
      end

      for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_out
        if (j < N) begin : g_live
          assign w_lvl_out[k][j] = r_node[j];
        end else begin : g_dead
          assign w_lvl_out[k][j] = '0;
        end
      end
      assign w_vld_out[k] = r_vld;
      assign w_lst_out[k] = r_lst;
    end else begin : g_wire
      for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_out
        assign w_lvl_out[k][j] = w_lvl_in[k][j];
      end
      assign w_vld_out[k] = w_vld_in[k];
      assign w_lst_out[k] = w_lst_in[k];
    end
  end

  // ---- accumulator stage ----
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_first;
  logic                 w_beat;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_addend;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  assign w_beat    = w_en && w_vld_out[NUM_STAGES];
  assign w_last    = w_lst_out[NUM_STAGES];
  assign w_addend  = ext_acc(w_lvl_out[NUM_STAGES][0]);
  assign w_base    = r_first ? '0 : r_acc;
  assign w_cnt_nxt = r_first ? CNT_W'(1) : r_cnt + CNT_W'(1);

`ifdef ADDER_TREE_ACCUM_SAT_EN
  logic [ACC_WIDTH:0] w_sat;
  logic               r_ovf_acc;
  logic               w_ovf_nxt;
  logic               r_o_ovf;
  assign w_sat     = sat_add(w_base, w_addend);
  assign w_acc_nxt = w_sat[ACC_WIDTH-1:0];
  assign w_ovf_nxt = (r_first ? 1'b0 : r_ovf_acc) | w_sat[ACC_WIDTH];
  assign o_ovf     = r_o_ovf;
`else
  assign w_acc_nxt = w_base + w_addend;
  assign o_ovf     = 1'b0;
`endif

  // Running frame sum, beat count and frame-start flag; advance once per tree output beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
`ifdef ADDER_TREE_ACCUM_SAT_EN
      r_ovf_acc <= 1'b0;
`endif
    end else if (w_beat) begin
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_first   <= w_last;
`ifdef ADDER_TREE_ACCUM_SAT_EN
      r_ovf_acc <= w_ovf_nxt;
`endif
    end
  end

  // ---- output register ----
  logic [ACC_WIDTH-1:0] r_o_sum;
  logic [CNT_W-1:0]     r_o_count;

  // Load the frame result on a last beat; otherwise drop valid once the sink takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_o_valid <= 1'b0;
      r_o_sum   <= '0;
      r_o_count <= '0;
`ifdef ADDER_TREE_ACCUM_SAT_EN
      r_o_ovf   <= 1'b0;
`endif
    end else if (w_beat && w_last) begin
      r_o_valid <= 1'b1;
      r_o_sum   <= w_acc_nxt;
      r_o_count <= w_cnt_nxt;
`ifdef ADDER_TREE_ACCUM_SAT_EN
      r_o_ovf   <= w_ovf_nxt;
`endif
    end else if (o_ready) begin
      r_o_valid <= 1'b0;
    end
  end

  assign o_valid = r_o_valid;
  assign o_sum   = r_o_sum;
  assign o_count = r_o_count;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Bench for adder_tree_accum: four instances (default unsigned, signed with a
// deeper pipeline, 10-bit accumulator, and a 5-input combinational tree).
`timescale 1ns/1ps
module tb_adder_tree_accum;
`ifdef ADDER_TREE_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] u;   // default unsigned instance sum
    logic        uo;  // default instance ovf
    logic [15:0] s;   // signed instance sum
    logic [9:0]  a;   // 10-bit accumulator instance sum
    logic        ao;  // 10-bit instance ovf
    logic [7:0]  c;   // beat count
  } exp_t;

  typedef struct {
    logic [63:0] pat;
    int          nb;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       tb_vld = 1'b0;
  logic       tb_last = 1'b0;
  logic       o_rdy = 1'b1;
  logic [3:0] d [16];
  logic       rdy0, rdy1, rdy3, all_rdy, vld_g;
  logic       ov0, ov1, ov3, oo0, oo1, oo3;
  logic [15:0] os0, os1;
  logic [9:0]  os3;
  logic [7:0]  oc0, oc1, oc3;

  logic [3:0]  d2 [5];
  logic        v2 = 1'b0, l2 = 1'b0, or2 = 1'b1;
  logic        rdy2, ov2, oo2;
  logic [15:0] os2;
  logic [7:0]  oc2;

  assign all_rdy = rdy0 & rdy1 & rdy3;
  assign vld_g   = tb_vld & all_rdy;

  adder_tree_accum u0 (
    .clk(clk), .rst(rst), .i_valid(vld_g), .i_ready(rdy0), .i_last(tb_last), .in_data(d),
    .o_valid(ov0), .o_ready(o_rdy), .o_sum(os0), .o_count(oc0), .o_ovf(oo0));

  adder_tree_accum #(.SIGNED(1), .NUM_PIPELINE_STAGES(3)) u1 (
    .clk(clk), .rst(rst), .i_valid(vld_g), .i_ready(rdy1), .i_last(tb_last), .in_data(d),
    .o_valid(ov1), .o_ready(o_rdy), .o_sum(os1), .o_count(oc1), .o_ovf(oo1));

  adder_tree_accum #(.ACC_WIDTH(10)) u3 (
    .clk(clk), .rst(rst), .i_valid(vld_g), .i_ready(rdy3), .i_last(tb_last), .in_data(d),
    .o_valid(ov3), .o_ready(o_rdy), .o_sum(os3), .o_count(oc3), .o_ovf(oo3));

  adder_tree_accum #(.NUM_INPUTS(5), .NUM_PIPELINE_STAGES(0)) u2 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_ready(rdy2), .i_last(l2), .in_data(d2),
    .o_valid(ov2), .o_ready(or2), .o_sum(os2), .o_count(oc2), .o_ovf(oo2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] u, input logic uo, input logic [15:0] s,
                              input logic [9:0] a, input logic ao, input logic [7:0] c);
    exp_t e;
    e.u = u; e.uo = uo; e.s = s; e.a = a; e.ao = ao; e.c = c;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [63:0] pat, input int nb, input exp_t e);
    vec_t v;
    v.pat = pat; v.nb = nb; v.e = e;
    return v;
  endfunction

  exp_t q0[$], q1[$], q3[$];
  exp_t e0, e1, e3;
  int oc_0 = 0, oc_1 = 0, oc_3 = 0;

  // Output monitors: one result per cycle where valid and ready meet.
  always @(negedge clk) begin
    if (rst && ov0 && o_rdy) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_extra_output: got sum 0x%0h expected no output", os0);
      end else begin
        e0 = q0.pop_front();
        chk("u0_sum", 32'(os0), 32'(e0.u));
        chk("u0_count", 32'(oc0), 32'(e0.c));
        chk("u0_ovf", 32'(oo0), 32'(e0.uo));
        oc_0 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov1 && o_rdy) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_extra_output: got sum 0x%0h expected no output", os1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_sum", 32'(os1), 32'(e1.s));
        chk("u1_count", 32'(oc1), 32'(e1.c));
        chk("u1_ovf", 32'(oo1), 32'd0);
        oc_1 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov3 && o_rdy) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL u3_extra_output: got sum 0x%0h expected no output", os3);
      end else begin
        e3 = q3.pop_front();
        chk("u3_sum", 32'(os3), 32'(e3.a));
        chk("u3_count", 32'(oc3), 32'(e3.c));
        chk("u3_ovf", 32'(oo3), 32'(e3.ao));
        oc_3 = cyc;
      end
    end
  end

  task automatic send(input logic [63:0] pat, input bit last, output int ac);
    int n;
    for (int j = 0; j < 16; j++) d[j] = pat[4*j +: 4];
    tb_last = last;
    tb_vld  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!all_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!all_rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout: i_ready got 0 expected 1");
    end
    ac = cyc;
    @(posedge clk); #1;
    tb_vld  = 1'b0;
    tb_last = 1'b0;
  endtask

  task automatic frame(input logic [63:0] pat, input int nb, input exp_t e, output int ac);
    for (int b = 0; b < nb; b++) send(pat, (b == nb - 1), ac);
    q0.push_back(e);
    q1.push_back(e);
    q3.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q3.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pending"}, 32'(q0.size() + q1.size() + q3.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_u0_valid"}, 32'(ov0), 32'd0);
    chk({tag, "_u0_sum"}, 32'(os0), 32'd0);
    chk({tag, "_u0_count"}, 32'(oc0), 32'd0);
    chk({tag, "_u0_ovf"}, 32'(oo0), 32'd0);
    chk({tag, "_u0_iready"}, 32'(rdy0), 32'd1);
    chk({tag, "_u1_valid"}, 32'(ov1), 32'd0);
    chk({tag, "_u1_sum"}, 32'(os1), 32'd0);
    chk({tag, "_u2_valid"}, 32'(ov2), 32'd0);
    chk({tag, "_u2_iready"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tv [8];
    int   ac;
    int   n;

    for (int j = 0; j < 16; j++) d[j] = 4'd0;
    for (int j = 0; j < 5; j++) d2[j] = 4'd0;

    tv[0] = mkv({16{4'hF}}, 3, mk(16'd720, 1'b0, 16'hFFD0, 10'd720, 1'b0, 8'd3));
    tv[1] = mkv({16{4'h8}}, 1, mk(16'd128, 1'b0, 16'hFF80, 10'd128, 1'b0, 8'd1));
    tv[2] = mkv({16{4'hF}}, 5, mk(16'd1200, 1'b0, 16'hFFB0,
                                  SAT ? 10'd1023 : 10'd176, SAT, 8'd5));
    tv[3] = mkv(64'hFEDCBA9876543210, 2, mk(16'd240, 1'b0, 16'hFFF0, 10'd240, 1'b0, 8'd2));
    tv[4] = mkv({16{4'h7}}, 1, mk(16'd112, 1'b0, 16'd112, 10'd112, 1'b0, 8'd1));
    tv[5] = mkv({16{4'h0}}, 4, mk(16'd0, 1'b0, 16'd0, 10'd0, 1'b0, 8'd4));
    tv[6] = mkv(64'hF1F1F1F1F1F1F1F1, 3, mk(16'd384, 1'b0, 16'd0, 10'd384, 1'b0, 8'd3));
    tv[7] = mkv({16{4'hF}}, 300, mk(SAT ? 16'hFFFF : 16'd6464, SAT, 16'hED40,
                                     SAT ? 10'd1023 : 10'd320, SAT, 8'd44));

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    reset_state("por");
    @(posedge clk); #1;

    // Table of frames with the sink always ready; latency measured per frame.
    for (int i = 0; i < 8; i++) begin
      frame(tv[i].pat, tv[i].nb, tv[i].e, ac);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_lat_u0", i), 32'(oc_0 - ac), 32'd2);
      chk($sformatf("vec%0d_lat_u1", i), 32'(oc_1 - ac), 32'd4);
      chk($sformatf("vec%0d_lat_u3", i), 32'(oc_3 - ac), 32'd2);
    end

    // Back-to-back single-beat frames with the sink stalled for four cycles.
    o_rdy = 1'b0;
    fork
      begin
        frame({16{4'h2}}, 1, mk(16'd32, 1'b0, 16'd32, 10'd32, 1'b0, 8'd1), ac);
        frame({16{4'h3}}, 1, mk(16'd48, 1'b0, 16'd48, 10'd48, 1'b0, 8'd1), ac);
        frame({16{4'h4}}, 1, mk(16'd64, 1'b0, 16'd64, 10'd64, 1'b0, 8'd1), ac);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!ov0 && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid", 32'(ov0), 32'd1);
        for (int k = 0; k < 4; k++) begin
          chk("stall_iready", 32'(rdy0), 32'd0);
          chk("stall_sum", 32'(os0), 32'd32);
          chk("stall_count", 32'(oc0), 32'd1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        o_rdy = 1'b1;
      end
    join
    drain("stall");

    // Reset in the middle of a frame, then a fresh single-beat frame.
    send({16{4'h5}}, 1'b0, ac);
    send({16{4'h5}}, 1'b0, ac);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    reset_state("midrst");
    @(posedge clk); #1;
    frame({16{4'h1}}, 1, mk(16'd16, 1'b0, 16'd16, 10'd16, 1'b0, 8'd1), ac);
    drain("midrst_frame");

    // Five-input combinational tree: odd pass-through and one-cycle latency.
    d2 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    v2 = 1'b1;
    l2 = 1'b1;
    @(negedge clk);
    chk("u2_iready", 32'(rdy2), 32'd1);
    chk("u2_pre_valid", 32'(ov2), 32'd0);
    @(posedge clk); #1;
    v2 = 1'b0;
    l2 = 1'b0;
    @(negedge clk);
    chk("u2_valid", 32'(ov2), 32'd1);
    chk("u2_sum", 32'(os2), 32'd15);
    chk("u2_count", 32'(oc2), 32'd1);
    chk("u2_ovf", 32'(oo2), 32'd0);
    @(negedge clk);
    chk("u2_valid_clears", 32'(ov2), 32'd0);
    @(posedge clk); #1;
    d2 = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    v2 = 1'b1;
    @(posedge clk); #1;
    d2 = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    l2 = 1'b1;
    @(negedge clk);
    chk("u2_nonlast_quiet", 32'(ov2), 32'd0);
    @(posedge clk); #1;
    v2 = 1'b0;
    l2 = 1'b0;
    @(negedge clk);
    chk("u2_two_beat_valid", 32'(ov2), 32'd1);
    chk("u2_two_beat_sum", 32'(os2), 32'd100);
    chk("u2_two_beat_count", 32'(oc2), 32'd2);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
